// File: rtl/load_store_unit.sv
// load_store_unit: load/store stage with byte/half/word lane steering, load extension and a bus timeout
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AccessErr,
  output logic        BusErr,
  output logic        dmem_valid,
  input  logic        dmem_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);
  // one spare count so a load accepted on the last cycle cannot wrap the counter
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] off;
  logic [2:0] f3;
  logic legal, expired;
  logic [3:0] strb_n;
  logic [31:0] wdata_n, lane, ext;
  always_comb begin
    legal = (Funct3 == 3'b000 || (Funct3 == 3'b100 && !MemWrite)) ? 1'b1 :
            (Funct3 == 3'b001 || (Funct3 == 3'b101 && !MemWrite)) ? !ALUResult[0] :
            (Funct3 == 3'b010) ? ALUResult[1:0] == 2'b00 : 1'b0;
    strb_n = Funct3[1] ? 4'b1111 : Funct3[0] ? (ALUResult[1] ? 4'b1100 : 4'b0011) : 4'b0001 << ALUResult[1:0];
    wdata_n = Funct3[1] ? WriteData : Funct3[0] ? {2{WriteData[15:0]}} : {4{WriteData[7:0]}};
    lane = dmem_rdata >> {off, 3'b000};
    ext = f3[1] ? lane : f3[0] ? {{16{!f3[2] && lane[15]}}, lane[15:0]} : {{24{!f3[2] && lane[7]}}, lane[7:0]};
    expired = cnt >= CW'(TIMEOUT - 1);
    Stall = state == IDLE ? (MemReq && legal) : (state != DONE);
    AccessErr = state == IDLE && MemReq && !legal;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      off        <= '0;
      f3         <= '0;
      ReadData   <= '0;
      BusErr     <= 1'b0;
      dmem_valid <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= '0;
    end else begin
      case (state)
        IDLE: if (MemReq && legal) begin
          state      <= REQ;
          cnt        <= '0;
          off        <= ALUResult[1:0];
          f3         <= Funct3;
          dmem_valid <= 1'b1;
          dmem_we    <= MemWrite;
          dmem_addr  <= {ALUResult[31:2], 2'b00};
          dmem_wdata <= wdata_n;
          dmem_wstrb <= MemWrite ? strb_n : 4'b0000;
        end
        REQ: begin
          cnt <= cnt + CW'(1);
          if (dmem_ready) begin
            dmem_valid <= 1'b0;
            state      <= dmem_we ? DONE : WAIT_RD;
          end else if (expired) begin
            dmem_valid <= 1'b0;
            state      <= DONE;
            BusErr     <= 1'b1;
            ReadData   <= '0;
          end
        end
        WAIT_RD: begin
          cnt <= cnt + CW'(1);
          if (dmem_rvalid) begin
            ReadData <= ext;
            state    <= DONE;
          end else if (expired) begin
            state    <= DONE;
            BusErr   <= 1'b1;
            ReadData <= '0;
          end
        end
        DONE: begin
          state  <= IDLE;
          BusErr <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized transactions checked every cycle against a transaction-level timeline model
module tb_load_store_unit;
  localparam int T = 16;
  logic clk = 0, rst_n;
  logic MemReq, MemWrite, dmem_ready, dmem_rvalid;
  logic [2:0] Funct3;
  logic [31:0] ALUResult, WriteData, dmem_rdata;
  logic [31:0] ReadData, dmem_addr, dmem_wdata;
  logic Stall, AccessErr, BusErr, dmem_valid, dmem_we;
  logic [3:0] dmem_wstrb;

  load_store_unit #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .MemReq(MemReq), .MemWrite(MemWrite), .Funct3(Funct3),
    .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
    .AccessErr(AccessErr), .BusErr(BusErr), .dmem_valid(dmem_valid), .dmem_ready(dmem_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit chk_en = 0;
  bit exp_stall, exp_aerr, exp_valid, exp_done, exp_to, exp_chkrd, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_rd;
  logic [3:0] exp_strb;
  bit lit_go = 0;
  string lit_name;
  logic [31:0] lit_act, lit_exp;
  int stall_tot = 0, v_tot = 0;
  logic [31:0] last_addr, last_wdata, last_rd;
  logic [3:0] last_strb;
  logic last_bus;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("stall", 32'(Stall), 32'(exp_stall));
    chk("accesserr", 32'(AccessErr), 32'(exp_aerr));
    chk("dmem_valid", 32'(dmem_valid), 32'(exp_valid));
    chk("buserr", 32'(BusErr), 32'(exp_done && exp_to));
    if (exp_valid) begin
      chk("dmem_we", 32'(dmem_we), 32'(exp_we));
      chk("dmem_addr", dmem_addr, exp_addr);
      chk("dmem_wstrb", 32'(dmem_wstrb), 32'(exp_strb));
      if (exp_we) chk("dmem_wdata", dmem_wdata, exp_wdata);
    end
    if (exp_done && exp_chkrd) chk("readdata", ReadData, exp_rd);
    if (lit_go) chk(lit_name, lit_act, lit_exp);
    stall_tot += int'(Stall);
    v_tot += int'(dmem_valid);
    if (dmem_valid) begin
      last_addr = dmem_addr;
      last_wdata = dmem_wdata;
      last_strb = dmem_wstrb;
    end
    if (exp_done) begin
      last_rd = ReadData;
      last_bus = BusErr;
    end
  end

  function automatic bit m_legal(input bit we, input logic [2:0] f, input logic [31:0] a);
    int s;
    if (!(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
    if (we && f[2]) return 0;
    s = 1 << f[1:0];
    return (a % s) == 0;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] wd);
    return f[1:0] == 2 ? wd : f[1:0] == 1 ? wd[15:0] * 32'h00010001 : wd[7:0] * 32'h01010101;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [1:0] o, input logic [31:0] rd);
    logic [63:0] v, span;
    int bits;
    bits = 8 * (1 << f[1:0]);
    span = 64'd1 << bits;
    v = {32'd0, rd >> (8 * o)} % span;
    if (!f[2] && bits < 32 && v >= (span >> 1)) v = v - span;
    return v[31:0];
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle;
    exp_stall = 0; exp_aerr = 0; exp_valid = 0; exp_done = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      MemReq = 0;
      dmem_ready = 1'($urandom);
      dmem_rvalid = 1'($urandom);
      set_idle;
      step;
    end
  endtask

  task automatic lit(input string n, input logic [31:0] a, input logic [31:0] e);
    MemReq = 0; dmem_ready = 0; dmem_rvalid = 0;
    set_idle;
    lit_name = n; lit_act = a; lit_exp = e; lit_go = 1;
    step;
    lit_go = 0;
  endtask

  // r: REQ cycle (from 0) in which ready rises; v: WAIT_RD cycles before rvalid
  task automatic xact(input bit we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input int r, input int v);
    bit lg, to, fin, inreq;
    int k, s;
    lg = m_legal(we, f, a);
    MemReq = 1; MemWrite = we; Funct3 = f; ALUResult = a; WriteData = wd; dmem_rdata = rd;
    dmem_ready = 1'($urandom); dmem_rvalid = 1'($urandom);
    exp_stall = lg; exp_aerr = !lg; exp_valid = 0; exp_done = 0;
    step;
    if (!lg) return;
    s = 1 << f[1:0];
    exp_we = we;
    exp_addr = a & ~32'd3;
    exp_strb = we ? 4'(((1 << s) - 1) << a[1:0]) : 4'd0;
    exp_wdata = m_wdata(f, wd);
    to = 0; fin = 0; inreq = 1; k = 0;
    while (!fin) begin
      exp_stall = 1; exp_aerr = 0; exp_valid = inreq;
      dmem_ready = inreq ? (k == r) : 1'($urandom);
      dmem_rvalid = inreq ? 1'($urandom) : (k == r + 1 + v);
      step;
      if (inreq && k == r) begin
        if (we) fin = 1;
        else inreq = 0;
      end else if (!inreq && k == r + 1 + v) fin = 1;
      else if (k >= T - 1) begin
        fin = 1;
        to = 1;
      end
      k++;
    end
    exp_stall = 0; exp_valid = 0; exp_done = 1; exp_to = to;
    exp_chkrd = to || !we;
    exp_rd = to ? 32'd0 : m_load(f, a[1:0], rd);
    dmem_ready = 1'($urandom); dmem_rvalid = 1'($urandom);
    step;
    exp_done = 0;
  endtask

  function automatic int pick;
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 20)) : int'($urandom_range(0, 3));
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    int s0, v0;
    rst_n = 0; MemReq = 0; MemWrite = 0; Funct3 = 0; ALUResult = 0; WriteData = 0;
    dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
    set_idle;
    repeat (3) step;
    rst_n = 1;
    chk_en = 1;
    lit("rst_readdata", ReadData, 0);
    lit("rst_buserr", 32'(BusErr), 0);
    lit("rst_valid", 32'(dmem_valid), 0);
    lit("rst_we", 32'(dmem_we), 0);
    lit("rst_addr", dmem_addr, 0);
    lit("rst_wdata", dmem_wdata, 0);
    lit("rst_wstrb", 32'(dmem_wstrb), 0);

    s0 = stall_tot;
    xact(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 2, 0);
    lit("sw_stall_cycles", stall_tot - s0, 4);
    lit("sw_wstrb", 32'(last_strb), 32'hF);
    lit("sw_addr", last_addr, 32'h100);
    lit("sw_wdata", last_wdata, 32'hDEADBEEF);

    xact(0, 3'b000, 32'h103, 0, 32'h80FF1234, 0, 1);
    lit("lb_readdata", last_rd, 32'hFFFFFF80);
    xact(0, 3'b100, 32'h103, 0, 32'h80FF1234, 1, 0);
    lit("lbu_readdata", last_rd, 32'h00000080);

    // reset while waiting for read data; the late rvalid must not be captured
    MemReq = 1; MemWrite = 0; Funct3 = 3'b010; ALUResult = 32'h200; dmem_ready = 0; dmem_rvalid = 0;
    exp_stall = 1; exp_aerr = 0; exp_valid = 0; exp_done = 0;
    step;
    dmem_ready = 1;
    exp_valid = 1; exp_we = 0; exp_addr = 32'h200; exp_strb = 0;
    step;
    rst_n = 0; dmem_ready = 0; chk_en = 0;
    step;
    rst_n = 1; MemReq = 0; dmem_ready = 1; dmem_rvalid = 1; dmem_rdata = 32'h12345678;
    set_idle; chk_en = 1;
    step;
    dmem_rvalid = 0;
    lit("rst_mid_readdata", ReadData, 0);
    lit("rst_mid_valid", 32'(dmem_valid), 0);

    xact(1, 3'b001, 32'h102, 32'h0000ABCD, 0, 1, 0);
    lit("sh_wstrb", 32'(last_strb), 32'hC);
    lit("sh_wdata", last_wdata, 32'hABCDABCD);

    s0 = stall_tot; v0 = v_tot;
    xact(0, 3'b010, 32'h101, 0, 0, 0, 0);
    idle(2);
    lit("lw_mis_valid_cycles", v_tot - v0, 0);
    lit("lw_mis_stall_cycles", stall_tot - s0, 0);

    s0 = stall_tot; v0 = v_tot;
    xact(0, 3'b000, 32'h40, 0, 32'h55, 100, 0);
    lit("timeout_buserr", 32'(last_bus), 1);
    lit("timeout_readdata", last_rd, 0);
    lit("timeout_valid_cycles", v_tot - v0, 16);
    lit("timeout_stall_cycles", stall_tot - s0, 17);

    for (int i = 0; i < 300; i++) begin
      logic [2:0] f;
      logic [31:0] a;
      bit we;
      f = 3'($urandom_range(0, 7));
      we = 1'($urandom);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f[1:0]) - 32'd1);
      xact(we, f, a, $urandom, $urandom, pick(), pick());
      idle($urandom_range(0, 2));
    end
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
